// File: rtl/matmul_seq_pkg.sv
// Shared definitions for the matrix-vector sequencer: state encoding and counter-width helper.
// Holds no logic, so there is no latency or backpressure here.
package matmul_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_MULT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Minimum width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/matmul_seq_cnt.sv
// Terminal counter with clear, load and increment; increment saturates at TERM.
// Latency 1 cycle from control to count; there is no backpressure, the parent gates inc.
module matmul_seq_cnt #(
   parameter int W    = 3,
   parameter int TERM = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         at_terminal
);

   assign at_terminal = (count == W'(TERM));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (ld) begin
         count <= ld_val;
      end else if (inc && !at_terminal) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the matrix-vector datapath: load, N_MAC accumulates, write-back per column, N_COL columns.
// Outputs decode from registered state; it waits on the load-done and ram_done handshakes; abort wins over all.
module matmul_seq_ctrl
   import matmul_seq_pkg::*;
#(
   parameter int N_COL  = 4,
   parameter int N_MAC  = 8,
   parameter int ADDR_W = cnt_width(N_COL),
   parameter int CNT_W  = cnt_width(N_MAC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_in,
   input  logic              abort_in,
   input  logic              reload_per_col,
   input  logic              xload_done,
   input  logic              aload_done,
   input  logic              ram_done,
   output logic              input_load_en,
   output logic              rom_start,
   output logic              alu_en,
   output logic              alu_clr,
   output logic              web,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              busy,
   output logic              finish
);

   state_t            state, state_nxt;
   logic              x_seen, a_seen, load_first;
   logic              enter_load, abort_act;
   logic              mac_clr, mac_inc, col_clr, col_inc;
   logic [CNT_W-1:0]  mac_cnt;
   logic              mac_term;
   logic [ADDR_W-1:0] col_idx;
   logic              col_term;

   assign abort_act = abort_in && (state != ST_IDLE);

   always_comb begin
      state_nxt  = state;
      enter_load = 1'b0;
      mac_clr    = 1'b0;
      mac_inc    = 1'b0;
      col_clr    = 1'b0;
      col_inc    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_in) begin
               state_nxt  = ST_LOAD;
               enter_load = 1'b1;
               col_clr    = 1'b1;
            end
         end
         ST_LOAD: begin
            if ((x_seen || xload_done) && (a_seen || aload_done)) begin
               state_nxt = ST_MULT;
            end
         end
         ST_MULT: begin
            mac_inc = 1'b1;
            if (mac_term) begin
               state_nxt = ST_WRITE;
               mac_clr   = 1'b1;
            end
         end
         ST_WRITE: begin
            if (ram_done) begin
               if (col_term) begin
                  state_nxt = ST_DONE;
               end else begin
                  col_inc = 1'b1;
                  if (reload_per_col) begin
                     state_nxt  = ST_LOAD;
                     enter_load = 1'b1;
                  end else begin
                     state_nxt = ST_MULT;
                  end
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            col_clr   = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Abort overrides whatever the state wanted, including a same-cycle ram_done.
      if (abort_act) begin
         state_nxt  = ST_IDLE;
         enter_load = 1'b0;
         mac_inc    = 1'b0;
         col_inc    = 1'b0;
         mac_clr    = 1'b1;
         col_clr    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Done inputs may be single-cycle pulses, so each is remembered until the pair is complete.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_seen     <= 1'b0;
         a_seen     <= 1'b0;
         load_first <= 1'b0;
      end else begin
         load_first <= enter_load;
         if (enter_load) begin
            x_seen <= 1'b0;
            a_seen <= 1'b0;
         end else if (state == ST_LOAD) begin
            x_seen <= x_seen || xload_done;
            a_seen <= a_seen || aload_done;
         end
      end
   end

   matmul_seq_cnt #(.W(CNT_W), .TERM(N_MAC - 1)) u_mac_cnt (
      .clk         (clk),
      .rst         (rst),
      .clr         (mac_clr),
      .ld          (1'b0),
      .ld_val      ('0),
      .inc         (mac_inc),
      .count       (mac_cnt),
      .at_terminal (mac_term)
   );

   matmul_seq_cnt #(.W(ADDR_W), .TERM(N_COL - 1)) u_col_cnt (
      .clk         (clk),
      .rst         (rst),
      .clr         (col_clr),
      .ld          (1'b0),
      .ld_val      ('0),
      .inc         (col_inc),
      .count       (col_idx),
      .at_terminal (col_term)
   );

   assign input_load_en = (state == ST_LOAD);
   assign rom_start     = (state == ST_LOAD) && load_first;
   assign alu_en        = (state == ST_MULT);
   assign alu_clr       = (state == ST_MULT) && (mac_cnt == '0);
   assign web           = (state != ST_WRITE);
   assign ram_addr      = col_idx;
   assign busy          = (state != ST_IDLE);
   assign finish        = (state == ST_DONE);

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench: three sequencer instances (4x8, 1x1, 3x5) share one environment; one is selected per job.
// Jobs are expanded into expected output events; a monitor reduces DUT outputs to events and compares.
module tb_matmul_seq_ctrl;

   localparam int EV_ROM = 0;
   localparam int EV_MAC = 1;
   localparam int EV_WR  = 2;
   localparam int EV_FIN = 3;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start_req, start_noise, abort_in, reload_per_col;
   logic       xload_done, aload_done, ram_done;
   logic [1:0] sel;
   logic [2:0] start_v;
   logic [2:0] o_load_en, o_rom, o_alu_en, o_alu_clr, o_web, o_busy, o_fin;
   logic [1:0] a0;
   logic [0:0] a1;
   logic [1:0] a2;

   logic m_load_en, m_rom, m_alu_en, m_alu_clr, m_web, m_busy, m_fin;
   int   m_addr;

   assign start_v[0] = (start_req || start_noise) && (sel == 2'd0);
   assign start_v[1] = (start_req || start_noise) && (sel == 2'd1);
   assign start_v[2] = (start_req || start_noise) && (sel == 2'd2);

   always_comb begin
      m_load_en = o_load_en[sel];
      m_rom     = o_rom[sel];
      m_alu_en  = o_alu_en[sel];
      m_alu_clr = o_alu_clr[sel];
      m_web     = o_web[sel];
      m_busy    = o_busy[sel];
      m_fin     = o_fin[sel];
      case (sel)
         2'd0:    m_addr = int'(a0);
         2'd1:    m_addr = int'(a1);
         default: m_addr = int'(a2);
      endcase
   end

   matmul_seq_ctrl #(.N_COL(4), .N_MAC(8), .ADDR_W(2), .CNT_W(3)) dut0 (
      .clk(clk), .rst(rst), .start_in(start_v[0]), .abort_in(abort_in),
      .reload_per_col(reload_per_col), .xload_done(xload_done), .aload_done(aload_done),
      .ram_done(ram_done), .input_load_en(o_load_en[0]), .rom_start(o_rom[0]),
      .alu_en(o_alu_en[0]), .alu_clr(o_alu_clr[0]), .web(o_web[0]), .ram_addr(a0),
      .busy(o_busy[0]), .finish(o_fin[0]));

   matmul_seq_ctrl #(.N_COL(1), .N_MAC(1), .ADDR_W(1), .CNT_W(1)) dut1 (
      .clk(clk), .rst(rst), .start_in(start_v[1]), .abort_in(abort_in),
      .reload_per_col(reload_per_col), .xload_done(xload_done), .aload_done(aload_done),
      .ram_done(ram_done), .input_load_en(o_load_en[1]), .rom_start(o_rom[1]),
      .alu_en(o_alu_en[1]), .alu_clr(o_alu_clr[1]), .web(o_web[1]), .ram_addr(a1),
      .busy(o_busy[1]), .finish(o_fin[1]));

   matmul_seq_ctrl #(.N_COL(3), .N_MAC(5), .ADDR_W(2), .CNT_W(3)) dut2 (
      .clk(clk), .rst(rst), .start_in(start_v[2]), .abort_in(abort_in),
      .reload_per_col(reload_per_col), .xload_done(xload_done), .aload_done(aload_done),
      .ram_done(ram_done), .input_load_en(o_load_en[2]), .rom_start(o_rom[2]),
      .alu_en(o_alu_en[2]), .alu_clr(o_alu_clr[2]), .web(o_web[2]), .ram_addr(a2),
      .busy(o_busy[2]), .finish(o_fin[2]));

   function automatic int ncol_of(input logic [1:0] k);
      case (k)
         2'd0:    return 4;
         2'd1:    return 1;
         default: return 3;
      endcase
   endfunction

   function automatic int nmac_of(input logic [1:0] k);
      case (k)
         2'd0:    return 8;
         2'd1:    return 1;
         default: return 5;
      endcase
   endfunction

   function automatic string ev_name(input int k);
      case (k)
         EV_ROM:  return "rom_start";
         EV_MAC:  return "mac_run";
         EV_WR:   return "write";
         default: return "finish";
      endcase
   endfunction

   ev_t exp_q[$];
   int  lat_q[$];
   int  wlen_q[$];
   int  vectors = 0;
   int  miscompares = 0;
   int  cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_msg(input string name, input int act);
      vectors++;
      miscompares++;
      $display("FAIL %s: got %0d with nothing expected (t=%0t)", name, act, $time);
   endtask

   task automatic push_ev(input int kind, input int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic got(input int kind, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         fail_msg({"unexpected_", ev_name(kind)}, val);
      end else begin
         e = exp_q.pop_front();
         chk({"event_kind_", ev_name(e.kind)}, kind, e.kind);
         chk({"event_val_", ev_name(e.kind)}, val, e.val);
      end
   endtask

   // ---------------- monitor ----------------
   int   mac_run = 0;
   int   wr_run = 0;
   int   wr_addr = 0;
   logic prev_load = 1'b0, prev_alu = 1'b0, prev_web = 1'b1, fin_prev = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (fin_prev) chk("busy_after_finish", int'(m_busy), 0);
         if (m_rom) begin
            chk("load_en_with_rom_start", int'(m_load_en), 1);
            got(EV_ROM, 0);
         end
         if (m_alu_en) begin
            if (!prev_alu) begin
               mac_run = 0;
               if (prev_load) begin
                  if (lat_q.size() == 0) fail_msg("mult_entry_unexpected", cyc);
                  else chk("mult_entry_cycle", cyc, lat_q.pop_front());
               end
            end
            chk("alu_clr", int'(m_alu_clr), (mac_run == 0) ? 1 : 0);
            mac_run++;
         end else if (prev_alu) begin
            got(EV_MAC, mac_run);
         end
         if (!m_web) begin
            if (prev_web) begin
               wr_addr = m_addr;
               wr_run  = 0;
               got(EV_WR, m_addr);
            end else begin
               chk("ram_addr_stable", m_addr, wr_addr);
            end
            chk("alu_en_during_write", int'(m_alu_en), 0);
            wr_run++;
         end else if (!prev_web) begin
            if (wlen_q.size() == 0) fail_msg("web_low_unexpected", wr_run);
            else chk("web_low_cycles", wr_run, wlen_q.pop_front());
         end
         if (m_fin) got(EV_FIN, 0);
         fin_prev  = m_fin;
         prev_load = m_load_en;
         prev_alu  = m_alu_en;
         prev_web  = m_web;
      end
   end

   // ---------------- environment responder ----------------
   int force_xd = -1, force_ad = -1, force_wd = -1, force_wcol = -1;
   int x_cnt, a_cnt, w_cnt;
   bit x_pend = 0, a_pend = 0, w_act = 0;

   initial begin
      xload_done = 1'b0;
      aload_done = 1'b0;
      ram_done   = 1'b0;
      forever begin
         step();
         xload_done = 1'b0;
         aload_done = 1'b0;
         ram_done   = 1'b0;
         if (!rst) begin
            x_pend = 0;
            a_pend = 0;
            w_act  = 0;
         end else begin
            if (m_rom) begin
               x_pend = 1;
               a_pend = 1;
               x_cnt  = (force_xd >= 0) ? force_xd : int'($urandom_range(0, 4));
               a_cnt  = (force_ad >= 0) ? force_ad : int'($urandom_range(0, 4));
            end
            if (x_pend) begin
               if (x_cnt == 0) begin
                  xload_done = 1'b1;
                  x_pend = 0;
                  if (!a_pend) lat_q.push_back(cyc + 1);
               end else x_cnt--;
            end
            if (a_pend) begin
               if (a_cnt == 0) begin
                  aload_done = 1'b1;
                  a_pend = 0;
                  if (!x_pend) lat_q.push_back(cyc + 1);
               end else a_cnt--;
            end
            if (!w_act && !m_web) begin
               w_act = 1;
               if (force_wd >= 0 && (force_wcol < 0 || m_addr == force_wcol)) w_cnt = force_wd;
               else w_cnt = int'($urandom_range(0, 3));
               wlen_q.push_back(w_cnt + 1);
            end
            if (w_act) begin
               if (w_cnt == 0) begin
                  ram_done = 1'b1;
                  w_act = 0;
               end else w_cnt--;
            end
         end
      end
   end

   // Spurious start requests while busy must be ignored.
   bit noise_en = 0;
   initial begin
      start_noise = 1'b0;
      forever begin
         step();
         start_noise = noise_en && m_busy && ($urandom_range(0, 5) == 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle();
      int n = 0;
      step();
      while ((exp_q.size() != 0 || m_busy) && n < 3000) begin
         step();
         n++;
      end
      if (n >= 3000) begin
         fail_msg("job_timeout_pending_events", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run_job(input logic [1:0] k, input bit rl);
      int nc = ncol_of(k);
      int nm = nmac_of(k);
      sel = k;
      reload_per_col = rl;
      push_ev(EV_ROM, 0);
      for (int c = 0; c < nc; c++) begin
         if (c > 0 && rl) push_ev(EV_ROM, 0);
         push_ev(EV_MAC, nm);
         push_ev(EV_WR, c);
      end
      push_ev(EV_FIN, 0);
      start_req = 1'b1;
      step();
      start_req = 1'b0;
      wait_idle();
   endtask

   task automatic wait_mult(input int addr, input int run);
      int n = 0;
      while (!(m_alu_en && m_addr == addr && mac_run == run) && n < 500) begin
         step();
         n++;
      end
      if (n >= 500) fail_msg("wait_mult_timeout", m_addr);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, int'(m_busy), 0);
      chk({tag, "_web"}, int'(m_web), 1);
      chk({tag, "_ram_addr"}, m_addr, 0);
      chk({tag, "_alu_en"}, int'(m_alu_en), 0);
      chk({tag, "_alu_clr"}, int'(m_alu_clr), 0);
      chk({tag, "_rom_start"}, int'(m_rom), 0);
      chk({tag, "_input_load_en"}, int'(m_load_en), 0);
      chk({tag, "_finish"}, int'(m_fin), 0);
   endtask

   initial begin
      rst = 1'b1;
      sel = 2'd0;
      start_req = 1'b0;
      abort_in = 1'b0;
      reload_per_col = 1'b0;
      #2 rst = 1'b0;
      repeat (3) step();
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         check_idle_outputs("reset");
      end
      sel = 2'd0;
      rst = 1'b1;
      repeat (2) step();

      // Directed: dones 2 cycles after load, ram_done 1 cycle after web falls.
      force_xd = 2; force_ad = 2; force_wd = 1; force_wcol = -1;
      run_job(2'd0, 1'b0);
      // Per-column reload.
      force_xd = -1; force_ad = -1; force_wd = -1;
      run_job(2'd0, 1'b1);
      // Done pulses three cycles apart.
      force_xd = 0; force_ad = 3;
      run_job(2'd0, 1'b1);
      force_xd = 3; force_ad = 0;
      run_job(2'd0, 1'b0);
      force_xd = -1; force_ad = -1;
      // Long ram_done wait on column 2.
      force_wd = 4; force_wcol = 2;
      run_job(2'd0, 1'b0);
      force_wd = -1; force_wcol = -1;

      // Abort in column 1 with mac_cnt = 4.
      sel = 2'd0;
      reload_per_col = 1'b0;
      push_ev(EV_ROM, 0);
      push_ev(EV_MAC, 8);
      push_ev(EV_WR, 0);
      push_ev(EV_MAC, 5);
      start_req = 1'b1;
      step();
      start_req = 1'b0;
      wait_mult(1, 5);
      abort_in = 1'b1;
      step();
      abort_in = 1'b0;
      check_idle_outputs("abort");
      repeat (4) step();
      chk("abort_events_consumed", exp_q.size(), 0);
      run_job(2'd0, 1'b0);

      // Reset in the middle of a job.
      push_ev(EV_ROM, 0);
      push_ev(EV_MAC, 3);
      reload_per_col = 1'b0;
      start_req = 1'b1;
      step();
      start_req = 1'b0;
      wait_mult(0, 3);
      rst = 1'b0;
      step();
      check_idle_outputs("midjob_reset");
      rst = 1'b1;
      repeat (3) step();
      chk("reset_events_consumed", exp_q.size(), 0);
      run_job(2'd0, 1'b1);

      // Parameter sweep instances with spurious starts while busy.
      noise_en = 1;
      for (int j = 0; j < 3; j++) run_job(2'd1, j[0]);
      for (int j = 0; j < 3; j++) run_job(2'd2, j[0]);

      // Randomised jobs across all instances.
      for (int j = 0; j < 24; j++) begin
         run_job(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end
      noise_en = 0;
      repeat (5) step();
      chk("final_queue_empty", exp_q.size() + lat_q.size() + wlen_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
